alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the team's 4-bit combinational ALU. It supports add, sub, AND, OR, XOR, logical shifts and a multi-cycle shift-add unsigned multiply, all behind a start/busy/done handshake. It also produces registered carry/overflow/zero/negative flags. It sits between the operand register file and the result bus, with one operation in flight at a time.

## Interface
Parameters:
- WIDTH, 8, operand/result width; power of two, ≥ 4.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- op  in  3  operation code, latched with start.
- A  in  WIDTH  operand A, latched with start.
- B  in  WIDTH  operand B, latched with start.
- S  out  WIDTH  result; low half of the product for MUL.
- hi  out  WIDTH  high half of the product for MUL; 0 for all other ops.
- C  out  1  carry / borrow / shifted-out bit.
- Ov  out  1  overflow flag.
- Z  out  1  zero flag.
- N  out  1  negative flag, equal to S[WIDTH-1].
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when S, hi and the flags are updated.

## Operation
- Op codes:
  - 000 ADD: A+B. C = carry out. Ov = signed overflow.
  - 001 SUB: A−B. C = borrow (A<B unsigned). Ov = signed overflow.
  - 010 AND, 011 OR, 100 XOR: bitwise. C=0, Ov=0.
  - 101 MUL: unsigned A×B, result {hi,S}. C = Ov = (hi≠0).
  - 110 SLL, 111 SRL: shift A by B[log2(WIDTH)-1:0]; upper bits of B are ignored. C = last bit shifted out (0 for amount 0). Ov=0.
- Z: for MUL, Z=1 iff {hi,S}=0. For all other ops, Z=1 iff S=0.
- FSM states:
  - IDLE: start=1 → latch op/A/B. Go to EXEC for all ops except MUL; go to MUL for MUL.
  - EXEC: compute and register S/hi/flags, pulse done, return to IDLE.
  - MUL: WIDTH shift-add iterations using a 2·WIDTH accumulator and an iteration counter 0..WIDTH-1. After the last iteration, register the outputs, pulse done and return to IDLE.
- busy = (state ≠ IDLE).
- start while busy=1 is ignored. It is not queued, and operands changing mid-operation have no effect.
- S, hi and the flags hold their values between done pulses. They change only on a done edge or on reset.

## Timing
- Reset value of all outputs: S=0, hi=0, C=0, Ov=0, Z=0, N=0, busy=0, done=0. State = IDLE, counter = 0.
- Let edge t0 be the rising edge that samples start=1 with busy=0. busy is high from t0.
- Single-cycle ops:
  - Outputs update and done rises at edge t0+1.
  - busy falls at t0+1.
  - done falls at t0+2.
- MUL:
  - Outputs update and done rises at edge t0+WIDTH+1; busy falls on that same edge.
  - Latency is 9 cycles for WIDTH=8.
- Back-to-back: start may be held high during the done cycle; the next op is then accepted at edge t0+2. Maximum throughput is one single-cycle op every 2 cycles.
- Reset asserted mid-operation: immediate return to reset values, with no done pulse. The first start after rst deasserts is accepted normally.
- Arithmetic uses a WIDTH+1-bit internal sum. MUL uses a 2·WIDTH-bit accumulator. No wrap-around except truncation of S to WIDTH bits.

## Test plan
All scenarios use WIDTH=8.
- ADD A=0x7F, B=0x01 → at t0+1: S=0x80, C=0, Ov=1, N=1, Z=0, done pulse exactly 1 cycle.
- SUB A=0x05, B=0x07 → S=0xFE, C=1, Ov=0, N=1. Then SUB 0x80−0x01 → S=0x7F, Ov=1, C=0.
- MUL A=0xFF, B=0xFF → done at t0+9 exactly, hi=0xFE, S=0x01, C=Ov=1, Z=0. Then MUL 0x00×0x37 → hi=0, S=0, Z=1, C=0.
- Shifts and logic:
  - SRL A=0x81, B=0x01 → S=0x40, C=1.
  - SLL A=0x81, B=0x09 (amount 1) → S=0x02, C=1.
  - XOR 0xAA,0xAA → S=0, Z=1.
  - AND 0xF0,0x3C → 0x30.
  - OR 0xF0,0x0F → 0xFF, N=1.
- Handshake:
  - Start MUL, pulse start with ADD at t0+3 → ignored; MUL result unchanged.
  - Hold start high across the done cycle → second op accepted at t0+2.
- Reset mid-MUL at t0+4 → all outputs 0 and busy=0 immediately, no done. A subsequent ADD 0x02+0x03 → S=0x05 at its t0+1.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered ALU with a start/busy/done handshake. Single-cycle
//            ops are add, sub, and, or, xor, sll and srl. MUL is an unsigned
//            shift-add multiply that takes WIDTH iterations and produces a
//            2*WIDTH-bit result in {hi,S}. Carry, overflow, zero and negative
//            flags are registered together with the result.
// Ports    : clk, rst (async, active-high)
//            start, op[2:0], A, B     - request; sampled only while busy=0
//            S, hi                    - result (hi is 0 except for MUL)
//            C, Ov, Z, N              - flags
//            busy, done               - handshake (done is a one-cycle pulse)
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] hi,
    output logic             C,
    output logic             Ov,
    output logic             Z,
    output logic             N,
    output logic             busy,
    output logic             done
);

    localparam int c_SHW = $clog2(WIDTH);
    localparam logic [c_SHW-1:0] c_CNT_LAST = c_SHW'(WIDTH - 1);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_MUL = 3'b101;
    localparam logic [2:0] c_OP_SLL = 3'b110;
    localparam logic [2:0] c_OP_SRL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_op;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [2*WIDTH-1:0]     r_acc;
    logic [c_SHW-1:0]       r_cnt;

    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [WIDTH:0]         w_sll;
    logic [WIDTH:0]         w_srl;
    logic [c_SHW-1:0]       w_amt;
    logic [WIDTH:0]         w_mul_sum;
    logic [WIDTH-1:0]       w_s;
    logic [WIDTH-1:0]       w_hi;
    logic                   w_c;
    logic                   w_ov;
    logic                   w_z;

    // One shift-add step: the low half of the accumulator holds the remaining
    // multiplier bits, the high half the partial product. The carry of the
    // add becomes the new top bit as the whole accumulator shifts right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

    assign w_amt  = r_b[c_SHW-1:0];
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    // Extra guard bit on each shift catches the last bit shifted out; for a
    // zero amount the guard bit stays 0.
    assign w_sll  = {1'b0, r_a} << w_amt;
    assign w_srl  = {r_a, 1'b0} >> w_amt;

    always_comb begin
        w_s  = '0;
        w_hi = '0;
        w_c  = 1'b0;
        w_ov = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_s  = w_sum[WIDTH-1:0];
                w_c  = w_sum[WIDTH];
                w_ov = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_s  = w_diff[WIDTH-1:0];
                w_c  = w_diff[WIDTH];
                w_ov = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_OP_AND: w_s = r_a & r_b;
            c_OP_OR:  w_s = r_a | r_b;
            c_OP_XOR: w_s = r_a ^ r_b;
            c_OP_MUL: begin
                w_s  = r_acc[WIDTH-1:0];
                w_hi = r_acc[2*WIDTH-1:WIDTH];
                w_c  = |r_acc[2*WIDTH-1:WIDTH];
                w_ov = |r_acc[2*WIDTH-1:WIDTH];
            end
            c_OP_SLL: begin
                w_s = w_sll[WIDTH-1:0];
                w_c = w_sll[WIDTH];
            end
            c_OP_SRL: begin
                w_s = w_srl[WIDTH:1];
                w_c = w_srl[0];
            end
            default: ;
        endcase
        w_z = ~|{w_hi, w_s};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            S       <= '0;
            hi      <= '0;
            C       <= 1'b0;
            Ov      <= 1'b0;
            Z       <= 1'b0;
            N       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_a   <= A;
                        r_b   <= B;
                        r_cnt <= '0;
                        busy  <= 1'b1;
                        if (op == c_OP_MUL) begin
                            r_acc   <= {{WIDTH{1'b0}}, B};
                            r_state <= ST_MUL;
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    if (r_cnt == c_CNT_LAST) begin
                        // Final product is published from EXEC on the next edge.
                        r_cnt   <= '0;
                        r_state <= ST_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    S       <= w_s;
                    hi      <= w_hi;
                    C       <= w_c;
                    Ov      <= w_ov;
                    Z       <= w_z;
                    N       <= w_s[WIDTH-1];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=8). Directed cases plus
//            randomized operations compared against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] hi;
    logic             C;
    logic             Ov;
    logic             Z;
    logic             N;
    logic             busy;
    logic             done;

    int n_tests;
    int n_fail;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .S     (S),
        .hi    (hi),
        .C     (C),
        .Ov    (Ov),
        .Z     (Z),
        .N     (N),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model from the arithmetic definition of each op.
    function automatic void model(input int opc, input int a, input int b,
                                  output int s, output int h, output int c,
                                  output int ov, output int z, output int n);
        int r, sa, sb, sr, amt;
        h = 0; c = 0; ov = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        amt = b % 8;
        case (opc)
            0: begin r = a + b; s = r % 256; c = r / 256; sr = sa + sb; ov = (sr > 127 || sr < -128) ? 1 : 0; end
            1: begin s = (a - b + 256) % 256; c = (a < b) ? 1 : 0; sr = sa - sb; ov = (sr > 127 || sr < -128) ? 1 : 0; end
            2: s = a & b;
            3: s = a | b;
            4: s = a ^ b;
            5: begin r = a * b; s = r % 256; h = r / 256; c = (h != 0) ? 1 : 0; ov = c; end
            6: begin s = (a * (1 << amt)) % 256; c = (amt == 0) ? 0 : (a / (1 << (8 - amt))) % 2; end
            default: begin s = a / (1 << amt); c = (amt == 0) ? 0 : (a / (1 << (amt - 1))) % 2; end
        endcase
        z = (s == 0 && h == 0) ? 1 : 0;
        n = s / 128;
    endfunction

    // Issue one op, wait for done within a bound, check latency, results and
    // that done lasts exactly one cycle with results held afterwards.
    task automatic run_op(input int opc, input int a, input int b, input string tag);
        int s, h, c, ov, z, n, lat, exp_lat;
        model(opc, a, b, s, h, c, ov, z, n);
        exp_lat = (opc == 5) ? WIDTH + 1 : 1;
        @(negedge clk);
        start = 1'b1; op = 3'(opc); A = 8'(a); B = 8'(b);
        @(posedge clk); #1;
        start = 1'b0; A = 8'($urandom); B = 8'($urandom);
        chk_val({tag, ".busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (lat < 20 && done !== 1'b1) begin
            @(posedge clk); #1;
            if (done !== 1'b1) lat++;
        end
        chk_val({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk_val({tag, ".S"},  32'(S),  32'(s));
        chk_val({tag, ".hi"}, 32'(hi), 32'(h));
        chk_val({tag, ".flags"}, {28'd0, C, Ov, Z, N}, 32'(c * 8 + ov * 4 + z * 2 + n));
        chk_val({tag, ".busy_end"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk_val({tag, ".done_fall"}, 32'(done), 32'd0);
        chk_val({tag, ".hold"}, {S, hi}, 32'((s << 8) | h) >> 0 == 0 ? 32'd0 : {16'd0, 8'(s), 8'(h)});
    endtask

    initial begin
        int s, h, c, ov, z, n, seen;
        n_tests = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst.outs", {S, hi, 10'd0, C, Ov, Z, N, busy, done}, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op(0, 8'h7F, 8'h01, "add_ovf");
        run_op(1, 8'h05, 8'h07, "sub_borrow");
        run_op(1, 8'h80, 8'h01, "sub_ovf");
        run_op(5, 8'hFF, 8'hFF, "mul_max");
        run_op(5, 8'h00, 8'h37, "mul_zero");
        run_op(7, 8'h81, 8'h01, "srl");
        run_op(6, 8'h81, 8'h09, "sll_mask");
        run_op(4, 8'hAA, 8'hAA, "xor_zero");
        run_op(2, 8'hF0, 8'h3C, "and");
        run_op(3, 8'hF0, 8'h0F, "or");
        run_op(6, 8'h5A, 8'h00, "sll_zero");

        // MUL with a stray ADD start at t0+3: must be ignored.
        @(negedge clk); start = 1'b1; op = 3'd5; A = 8'd13; B = 8'd21;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1; op = 3'd0; A = 8'd1; B = 8'd1;
        @(posedge clk); #1; start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1;
        end
        chk_val("ign.done", 32'(seen), 32'd1);
        chk_val("ign.prod", {16'd0, hi, S}, 32'd273);
        @(posedge clk); #1;
        chk_val("ign.idle", {30'd0, busy, done}, 32'd0);

        // Start held across the done cycle: second op accepted at t0+2.
        @(negedge clk); start = 1'b1; op = 3'd0; A = 8'h10; B = 8'h22;
        @(posedge clk); #1; op = 3'd1; A = 8'h09; B = 8'h04;
        @(posedge clk); #1;
        chk_val("b2b.done1", 32'(done), 32'd1);
        chk_val("b2b.S1", 32'(S), 32'h32);
        @(posedge clk); #1; start = 1'b0;
        chk_val("b2b.busy2", {30'd0, busy, done}, 32'd2);
        @(posedge clk); #1;
        chk_val("b2b.done2", 32'(done), 32'd1);
        chk_val("b2b.S2", 32'(S), 32'h05);
        @(posedge clk); #1;

        // Reset between t0+3 and t0+4 of a MUL: immediate clear, no done.
        @(negedge clk); start = 1'b1; op = 3'd5; A = 8'hFF; B = 8'hFF;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        rst = 1'b1; #1;
        chk_val("rstmid.outs", {S, hi, 10'd0, C, Ov, Z, N, busy, done}, 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1;
        end
        chk_val("rstmid.nodone", 32'(seen), 32'd0);
        run_op(0, 8'h02, 8'h03, "add_after_rst");

        // Randomized operations against the model.
        for (int i = 0; i < 150; i++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
